// File: rtl/xm23_alu_core.sv
// xm23_alu_core: registered ALU for the XM23 CPU.
// Computes a result and an updated PSW from the S/D operand buses. Both are
// registered one clock after a request is sampled with alu_E high.
// Optional build macro: XM23_ALU_DADD_EN enables BCD add on opcode 4.
// Without it, opcode 4 behaves as a reserved op.
module xm23_alu_core #(
   parameter int WIDTH = 16  // only 16 is supported
) (
   input  logic             Clock,
   input  logic             Reset_n,
   input  logic             alu_E,
   input  logic             psw_update,
   input  logic [5:0]       alu_op,
   input  logic [WIDTH-1:0] s_bus,
   input  logic [WIDTH-1:0] d_bus,
   input  logic [WIDTH-1:0] psw_in,
   output logic [WIDTH-1:0] alu_out,
   output logic [WIDTH-1:0] psw_out
);

   typedef enum logic [4:0] {
      OP_ADD  = 5'd0,
      OP_ADDC = 5'd1,
      OP_SUB  = 5'd2,
      OP_SUBC = 5'd3,
      OP_DADD = 5'd4,
      OP_CMP  = 5'd5,
      OP_XOR  = 5'd6,
      OP_AND  = 5'd7,
      OP_OR   = 5'd8,
      OP_BIT  = 5'd9,
      OP_BIC  = 5'd10,
      OP_BIS  = 5'd11,
      OP_MOV  = 5'd12,
      OP_SRA  = 5'd13,
      OP_RRC  = 5'd14,
      OP_SWPB = 5'd15,
      OP_SXT  = 5'd16
   } op_e;

   op_e         op;
   logic        byte_m;
   logic        cin;

   logic [15:0] add_b;
   logic        add_ci;
   logic [16:0] sum_w;
   logic [8:0]  sum_b;

   logic [15:0] res;
   logic        c_f;
   logic        v_f;
   logic        z_f;
   logic        n_f;
   logic        wr_res;
   logic        upd_c;
   logic        upd_zn;
   logic        upd_v;
   logic        byte_flags;
   logic [15:0] psw_new;

   logic [15:0] alu_out_d, alu_out_q;
   logic [15:0] psw_out_d, psw_out_q;

   assign op     = op_e'(alu_op[4:0]);
   assign byte_m = alu_op[5];
   assign cin    = psw_in[0];

`ifdef XM23_ALU_DADD_EN
   // BCD add: returns {carry, result}. Each nibble above 9 is adjusted by 6
   // and carries into the next nibble. In byte mode the carry comes out of
   // nibble 1 and the high byte is passed through from a.
   function automatic logic [16:0] bcd_add(input logic [15:0] a,
                                           input logic [15:0] b,
                                           input logic        c_in,
                                           input logic        byte_sel);
      logic [4:0]  ns;
      logic        c;
      logic        c_byte;
      logic [15:0] r;
      c      = c_in;
      c_byte = 1'b0;
      r      = 16'd0;
      for (int i = 0; i < 4; i++) begin
         ns = {1'b0, a[4*i +: 4]} + {1'b0, b[4*i +: 4]} + {4'd0, c};
         if (ns > 5'd9) begin
            ns = ns + 5'd6;
            c  = 1'b1;
         end else begin
            c  = 1'b0;
         end
         r[4*i +: 4] = ns[3:0];
         if (i == 1) c_byte = c;
      end
      return byte_sel ? {c_byte, a[15:8], r[7:0]} : {c, r};
   endfunction

   logic [16:0] dadd_res;
   assign dadd_res = bcd_add(d_bus, s_bus, cin, byte_m);
`endif

   // Select the second addend and the carry-in for the shared adder.
   always_comb begin
      // NOTE: every always_comb output gets a default first so that no path
      // leaves it unassigned and infers a latch.
      add_b  = s_bus;
      add_ci = 1'b0;
      case (op)
         OP_ADDC:        add_ci = cin;
         OP_SUB, OP_CMP: begin
            add_b  = ~s_bus;
            add_ci = 1'b1;
         end
         OP_SUBC: begin
            add_b  = ~s_bus;
            add_ci = cin;
         end
         default: ;
      endcase
   end

   // The adder runs at both widths. Byte mode uses the carry out of bit 7.
   assign sum_w = {1'b0, d_bus} + {1'b0, add_b} + {16'd0, add_ci};
   assign sum_b = {1'b0, d_bus[7:0]} + {1'b0, add_b[7:0]} + {8'd0, add_ci};

   // Compute the result and the flags. This block also decides which PSW
   // bits the operation may change.
   always_comb begin
      res    = d_bus;
      c_f    = cin;
      v_f    = psw_in[4];
      wr_res = 1'b1;
      upd_c  = 1'b0;
      upd_zn = 1'b0;
      upd_v  = 1'b0;
      case (op)
         OP_ADD, OP_ADDC, OP_SUB, OP_SUBC, OP_CMP: begin
            res    = byte_m ? {d_bus[15:8], sum_b[7:0]} : sum_w[15:0];
            c_f    = byte_m ? sum_b[8] : sum_w[16];
            v_f    = byte_m ? ((d_bus[7] == add_b[7]) && (res[7] != d_bus[7]))
                            : ((d_bus[15] == add_b[15]) && (res[15] != d_bus[15]));
            wr_res = (op != OP_CMP);
            upd_c  = 1'b1;
            upd_zn = 1'b1;
            upd_v  = 1'b1;
         end
`ifdef XM23_ALU_DADD_EN
         OP_DADD: begin
            res    = dadd_res[15:0];
            c_f    = dadd_res[16];
            upd_c  = 1'b1;
            upd_zn = 1'b1;
         end
`endif
         OP_XOR, OP_AND, OP_OR, OP_BIT, OP_BIC, OP_BIS: begin
            case (op)
               OP_XOR:        res = d_bus ^ s_bus;
               OP_AND, OP_BIT: res = d_bus & s_bus;
               OP_BIC:        res = d_bus & ~s_bus;
               default:       res = d_bus | s_bus;
            endcase
            if (byte_m) res[15:8] = d_bus[15:8];
            wr_res = (op != OP_BIT);
            upd_zn = 1'b1;
         end
         OP_MOV: res = byte_m ? {d_bus[15:8], s_bus[7:0]} : s_bus;
         OP_SRA: begin
            res    = byte_m ? {d_bus[15:8], d_bus[7], d_bus[7:1]}
                            : {d_bus[15], d_bus[15:1]};
            c_f    = d_bus[0];
            upd_c  = 1'b1;
            upd_zn = 1'b1;
         end
         OP_RRC: begin
            res    = byte_m ? {d_bus[15:8], cin, d_bus[7:1]}
                            : {cin, d_bus[15:1]};
            c_f    = d_bus[0];
            upd_c  = 1'b1;
            upd_zn = 1'b1;
         end
         OP_SWPB: begin
            res    = {d_bus[7:0], d_bus[15:8]};
            upd_zn = 1'b1;
         end
         OP_SXT: begin
            res    = {{8{d_bus[7]}}, d_bus[7:0]};
            upd_zn = 1'b1;
         end
         default: ;  // reserved: result = D, flags unchanged
      endcase

      // SWPB and SXT always work on the full word.
      byte_flags = byte_m && (op != OP_SWPB) && (op != OP_SXT);
      n_f        = byte_flags ? res[7] : res[15];
      z_f        = byte_flags ? (res[7:0] == 8'd0) : (res == 16'd0);
   end

   // Merge the computed flags into the incoming PSW. SLP and bits 15:5
   // always pass through unchanged.
   always_comb begin
      psw_new = psw_in;
      if (psw_update) begin
         if (upd_c) psw_new[0] = c_f;
         if (upd_zn) begin
            psw_new[1] = z_f;
            psw_new[2] = n_f;
         end
         if (upd_v) psw_new[4] = v_f;
      end
   end

   // Next state of the output registers. Both hold while alu_E is low.
   // Flags-only ops also hold alu_out.
   always_comb begin
      alu_out_d = alu_out_q;
      psw_out_d = psw_out_q;
      if (alu_E) begin
         if (wr_res) alu_out_d = res;
         psw_out_d = psw_new;
      end
   end

   // Output registers with asynchronous clear.
   always_ff @(posedge Clock or negedge Reset_n) begin
      // NOTE: non-blocking assignments, so every flop samples its pre-edge
      // inputs regardless of the order in which blocks are evaluated.
      if (!Reset_n) begin
         alu_out_q <= 16'h0000;
         psw_out_q <= 16'h0000;
      end else begin
         alu_out_q <= alu_out_d;
         psw_out_q <= psw_out_d;
      end
   end

   assign alu_out = alu_out_q;
   assign psw_out = psw_out_q;

endmodule

// File: tb/tb_xm23_alu_core.sv
// tb_xm23_alu_core: scoreboard bench for xm23_alu_core.
// The stimulus pushes an expected {alu_out, psw_out} for each enabled request.
// A monitor pops and compares one clock later. Reset and hold behaviour are
// checked directly.
module tb_xm23_alu_core;

   localparam logic W = 1'b0;
   localparam logic B = 1'b1;

   logic        Clock = 1'b0;
   logic        Reset_n = 1'b0;
   logic        alu_E;
   logic        psw_update;
   logic [5:0]  alu_op;
   logic [15:0] s_bus;
   logic [15:0] d_bus;
   logic [15:0] psw_in;
   logic [15:0] alu_out;
   logic [15:0] psw_out;

   typedef struct {
      logic [15:0] out;
      logic [15:0] psw;
      string       name;
   } exp_t;

   exp_t sb[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   logic fire = 1'b0;

   xm23_alu_core #(.WIDTH(16)) dut (
      .Clock     (Clock),
      .Reset_n   (Reset_n),
      .alu_E     (alu_E),
      .psw_update(psw_update),
      .alu_op    (alu_op),
      .s_bus     (s_bus),
      .d_bus     (d_bus),
      .psw_in    (psw_in),
      .alu_out   (alu_out),
      .psw_out   (psw_out)
   );

   always #5 Clock = ~Clock;

   task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%04h, expected 0x%04h", nm, act, exp);
      end
   endtask

   // Issue one enabled request at the falling edge and record its expected response.
   task automatic issue(input logic [5:0] op, input logic [15:0] d, input logic [15:0] s,
                        input logic [15:0] psw, input logic upd,
                        input logic [15:0] exp_out, input logic [15:0] exp_psw,
                        input string nm);
      exp_t e;
      @(negedge Clock);
      alu_E      = 1'b1;
      alu_op     = op;
      d_bus      = d;
      s_bus      = s;
      psw_in     = psw;
      psw_update = upd;
      e.out  = exp_out;
      e.psw  = exp_psw;
      e.name = nm;
      sb.push_back(e);
   endtask

   // Record which rising edges captured a request.
   always @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) fire <= 1'b0;
      else          fire <= alu_E;
   end

   // Monitor: compare the registered outputs after each captured request.
   always @(negedge Clock) begin
      if (fire) begin
         if (sb.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_output: got alu_out=0x%04h psw_out=0x%04h, expected no output",
                     alu_out, psw_out);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check({e.name, "_out"}, alu_out, e.out);
            check({e.name, "_psw"}, psw_out, e.psw);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got simulation still running, expected it to finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      alu_E      = 1'b0;
      psw_update = 1'b0;
      alu_op     = 6'd0;
      s_bus      = 16'h0000;
      d_bus      = 16'h0000;
      psw_in     = 16'h0000;

      @(posedge Clock);
      #1;
      check("reset_out", alu_out, 16'h0000);
      check("reset_psw", psw_out, 16'h0000);
      @(negedge Clock);
      Reset_n = 1'b1;

      //     op          D         S         psw_in    upd   exp_out   exp_psw
      issue({W, 5'd0},  16'h7FFF, 16'h0001, 16'h60E0, 1'b1, 16'h8000, 16'h60F4, "add_ovf");
      issue({W, 5'd2},  16'h0005, 16'h0005, 16'h0000, 1'b1, 16'h0000, 16'h0003, "sub_eq");
      issue({W, 5'd5},  16'h0003, 16'h0005, 16'h0000, 1'b1, 16'h0000, 16'h0004, "cmp_lt");
      issue({B, 5'd0},  16'h12FF, 16'h0001, 16'h0000, 1'b1, 16'h1200, 16'h0003, "add_byte");
      issue({B, 5'd0},  16'h12FF, 16'h0001, 16'h0A18, 1'b0, 16'h1200, 16'h0A18, "add_byte_noupd");
`ifdef XM23_ALU_DADD_EN
      issue({W, 5'd4},  16'h0199, 16'h0001, 16'h0016, 1'b1, 16'h0200, 16'h0010, "dadd");
`else
      issue({W, 5'd4},  16'h0199, 16'h0001, 16'h0016, 1'b1, 16'h0199, 16'h0016, "dadd_reserved");
`endif
      issue({W, 5'd14}, 16'h0001, 16'h0000, 16'h0000, 1'b1, 16'h0000, 16'h0003, "rrc");
      issue({W, 5'd16}, 16'h0080, 16'h0000, 16'h0000, 1'b1, 16'hFF80, 16'h0004, "sxt");
      issue({B, 5'd15}, 16'h0080, 16'h0000, 16'h0000, 1'b1, 16'h8000, 16'h0004, "swpb_byte");
      issue({W, 5'd1},  16'hFFFF, 16'h0000, 16'h0001, 1'b1, 16'h0000, 16'h0003, "addc");
      issue({W, 5'd3},  16'h0005, 16'h0003, 16'h0000, 1'b1, 16'h0001, 16'h0001, "subc");
      issue({W, 5'd6},  16'hF0F0, 16'hF0F0, 16'h0011, 1'b1, 16'h0000, 16'h0013, "xor");
      issue({W, 5'd7},  16'hFF00, 16'h8F0F, 16'h0000, 1'b1, 16'h8F00, 16'h0004, "and");
      issue({B, 5'd8},  16'hAB00, 16'h1280, 16'h0000, 1'b1, 16'hAB80, 16'h0004, "or_byte");
      issue({W, 5'd9},  16'h00F0, 16'h000F, 16'h0000, 1'b1, 16'hAB80, 16'h0002, "bit");
      issue({W, 5'd10}, 16'hFFFF, 16'h00FF, 16'h0000, 1'b1, 16'hFF00, 16'h0004, "bic");
      issue({W, 5'd11}, 16'h0001, 16'h0002, 16'h0005, 1'b1, 16'h0003, 16'h0001, "bis");
      issue({W, 5'd12}, 16'hFFFF, 16'h1234, 16'h0017, 1'b1, 16'h1234, 16'h0017, "mov");
      issue({W, 5'd13}, 16'h8003, 16'h0000, 16'h0010, 1'b1, 16'hC001, 16'h0015, "sra");
      issue({W, 5'd20}, 16'hBEEF, 16'h0000, 16'h0017, 1'b1, 16'hBEEF, 16'h0017, "reserved");
      issue({B, 5'd2},  16'h5500, 16'h0001, 16'h0000, 1'b1, 16'h55FF, 16'h0004, "sub_byte");
      issue({W, 5'd0},  16'h8000, 16'h8000, 16'hFFE8, 1'b1, 16'h0000, 16'hFFFB, "add_wrap");
      issue({W, 5'd12}, 16'h0000, 16'hA5C3, 16'h1234, 1'b1, 16'hA5C3, 16'h1234, "mov_last");

      // With alu_E low, the outputs hold while the inputs change.
      @(negedge Clock);
      alu_E  = 1'b0;
      alu_op = {W, 5'd0};
      d_bus  = 16'h1111;
      s_bus  = 16'h2222;
      psw_in = 16'h0007;
      for (int i = 0; i < 3; i++) begin
         @(negedge Clock);
         check("hold_out", alu_out, 16'hA5C3);
         check("hold_psw", psw_out, 16'h1234);
      end

      // Assert reset with a request pending. It clears immediately, and the request is dropped.
      alu_E      = 1'b1;
      psw_update = 1'b1;
      d_bus      = 16'h0001;
      s_bus      = 16'h0001;
      #2;
      Reset_n = 1'b0;
      #1;
      check("rst_async_out", alu_out, 16'h0000);
      check("rst_async_psw", psw_out, 16'h0000);
      @(negedge Clock);
      check("rst_held_out", alu_out, 16'h0000);
      check("rst_held_psw", psw_out, 16'h0000);
      alu_E   = 1'b0;
      Reset_n = 1'b1;
      @(negedge Clock);
      check("post_rst_out", alu_out, 16'h0000);
      check("post_rst_psw", psw_out, 16'h0000);

      issue({W, 5'd0}, 16'h0001, 16'h0001, 16'h0100, 1'b1, 16'h0002, 16'h0100, "add_after_rst");
      @(negedge Clock);
      alu_E = 1'b0;
      @(negedge Clock);
      check("sb_drained", 16'(sb.size()), 16'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
